abs_diff_err_monitor: RTL and testbench
=======================================

// Module: abs_diff_err_monitor
// PURPOSE
// Parametrised, pipelined error monitor for approximate abs-diff circuits. Computes exact |a-b| for
// each sample, compares it with the approximate result returned by the circuit under evaluation,
// and accumulates max error, violation count (err > ET) and sample count.
// In MODE=1 an internal exhaustive sweep generator drives every operand pair.
// Sits between a stream source (or the sweep generator) and the approximate SOP netlist.
// PARAMETERS
// W      4   operand width (2*W circuit inputs)
// OUT_W  5   result width; must be >= W
// ET     6   error threshold; err > ET flags a violation
// CNT_W  16  width of violation and sample counters (saturating)
// MODE   0   0 = external stream input; 1 = internal exhaustive sweep
// PORTS
// clk         in   1      clock, all logic on rising edge
// rst         in   1      synchronous active-high reset
// start       in   1      MODE=1: pulse to begin a sweep; ignored when MODE=0
// clear       in   1      synchronous clear of statistics
// in_valid    in   1      MODE=0: sample valid
// in_ready    out  1      MODE=0: sample accepted when in_valid&&in_ready; 0 when MODE=1
// in_a        in   W      MODE=0: operand a (unsigned)
// in_b        in   W      MODE=0: operand b (unsigned)
// sweep_a     out  W      MODE=1: operand a driven to the approximate circuit
// sweep_b     out  W      MODE=1: operand b driven to the approximate circuit
// in_approx   in   OUT_W  approximate result for the operands presented this cycle (combinational return)
// out_valid   out  1      result beat valid
// out_ready   in   1      downstream accepts the beat
// out_exact   out  OUT_W  exact |a-b|, zero-extended
// out_err     out  OUT_W  |out_exact - approx|
// out_viol    out  1      out_err > ET
// max_err     out  OUT_W  largest out_err accepted since the last clear
// viol_cnt    out  CNT_W  accepted beats with out_viol=1
// sample_cnt  out  CNT_W  accepted beats
// sweep_busy  out  1      FSM is in SWEEP or DRAIN
// sweep_done  out  1      FSM is in DONE
// BEHAVIOUR
// - Reset: every output 0; FSM in IDLE; pipeline empty; sweep index 0.
// - Pipeline: 2 stages. S1 registers a, b, approx. S2 registers exact, err, viol.
//   Latency is 2 cycles from accept to out_valid when there is no stall.
// - Stall: a stage loads when it is empty or when its successor advances. in_ready = !S1v || S1 advances.
//   A beat is retired on out_valid&&out_ready. No drops, no duplicates, order preserved.
// - Arithmetic: exact = (a>=b) ? a-b : b-a. err is computed as an OUT_W+1-bit difference,
//   then the absolute value is taken; the result fits in OUT_W.
// - Stats: updated on a retired beat. sample_cnt+1, viol_cnt+out_viol, max_err=max(max_err,out_err).
//   Counters saturate at all-ones.
// - clear has priority: stats go to 0 and a beat retiring in the same cycle is not counted,
//   but it is still delivered.
// - FSM (MODE=1):
//   - IDLE -start-> SWEEP (stats cleared).
//   - SWEEP: index idx runs 0 .. 2^(2W)-1, with sweep_a = idx[2W-1:W] and sweep_b = idx[W-1:0].
//     S1 loads a new sample when free, and idx advances on each load.
//   - After idx = max is loaded, go to DRAIN.
//   - DRAIN: go to DONE once both stages are empty.
//   - DONE: hold stats. start -> SWEEP (stats cleared, idx = 0).
//   - start is ignored in SWEEP and DRAIN.
// - MODE=0: FSM stays in IDLE; sweep_a/b = 0; sweep_busy = sweep_done = 0.
// - rst mid-sweep: immediate return to the reset state; in-flight beats are discarded.
// TESTING
// 1. MODE0: a=9, b=3, approx=6, out_ready=1 -> 2 cycles later exact=6, err=0, viol=0; sample_cnt=1.
// 2. MODE0: a=0, b=15, approx=4 -> exact=15, err=11, viol=1; viol_cnt=1, max_err=11.
// 3. MODE0: 3 back-to-back beats, out_ready=0 for 5 cycles -> in_ready=0 once 2 beats are held;
//    all 3 delivered in order, no loss.
// 4. MODE1: approx tied to 0, start pulse -> sample_cnt=256, max_err=15, viol_cnt=90, sweep_done=1.
// 5. MODE1: rst asserted at idx=100 -> all outputs 0, IDLE; a new start gives a full 256-sample sweep.
// 6. CNT_W=4: 20 violating beats -> viol_cnt holds at 15. clear concurrent with a retire -> stats 0, beat delivered.

Source files
------------

// File: rtl/abs_diff_err_monitor_if.sv
// rtl/abs_diff_err_monitor_if.sv - sample/result stream bundle for the abs-diff error monitor
interface abs_diff_err_monitor_if #(
  parameter int W     = 4,
  parameter int OUT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     sweep_a;
  logic [W-1:0]     sweep_b;
  logic [OUT_W-1:0] in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_exact;
  logic [OUT_W-1:0] out_err;
  logic             out_viol;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, sweep_a, sweep_b, out_valid, out_exact, out_err, out_viol
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, sweep_a, sweep_b, out_valid, out_exact, out_err, out_viol
  );
endinterface

// File: rtl/abs_diff_err_monitor.sv
// rtl/abs_diff_err_monitor.sv - pipelined exact-vs-approximate |a-b| error monitor
// Two-stage elastic pipeline with saturating statistics and an optional exhaustive sweep source.
module abs_diff_err_monitor #(
  parameter int W     = 4,
  parameter int OUT_W = 5,
  parameter int ET    = 6,
  parameter int CNT_W = 16,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  abs_diff_err_monitor_if.slave bus,
  output logic [OUT_W-1:0]     max_err,
  output logic [CNT_W-1:0]     viol_cnt,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic                 sweep_busy,
  output logic                 sweep_done
);
  localparam int IW = 2 * W;
  localparam logic [IW-1:0]    IDX_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              s1_v_q, s1_v_d;
  logic [W-1:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [OUT_W-1:0]  s1_apx_q, s1_apx_d;
  logic              s2_v_q, s2_v_d;
  logic [OUT_W-1:0]  s2_exact_q, s2_exact_d, s2_err_q, s2_err_d;
  logic              s2_viol_q, s2_viol_d;
  logic [OUT_W-1:0]  max_err_q, max_err_d;
  logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d, sample_cnt_q, sample_cnt_d;

  logic              s2_adv, s1_adv, s1_free, src_valid, load, retire, sweep_start, clr;
  logic [W-1:0]      src_a, src_b, diff;
  logic [OUT_W-1:0]  exact, err_lo, err;
  logic [OUT_W:0]    err_wide;

  always_comb begin
    s2_adv      = !s2_v_q || bus.out_ready;
    s1_adv      = s1_v_q && s2_adv;
    s1_free     = !s1_v_q || s2_adv;
    src_valid   = (MODE == 1) ? (state_q == SWEEP) : bus.in_valid;
    src_a       = (MODE == 1) ? idx_q[IW-1:W] : bus.in_a;
    src_b       = (MODE == 1) ? idx_q[W-1:0]  : bus.in_b;
    load        = src_valid && s1_free;
    retire      = s2_v_q && bus.out_ready;
    sweep_start = (MODE == 1) && start && ((state_q == IDLE) || (state_q == DONE));
    clr         = clear || sweep_start;

    // Error is formed one bit wider so a negative difference can be folded back to a magnitude.
    diff     = (s1_a_q >= s1_b_q) ? (s1_a_q - s1_b_q) : (s1_b_q - s1_a_q);
    exact    = OUT_W'(diff);
    err_wide = {1'b0, exact} - {1'b0, s1_apx_q};
    err_lo   = err_wide[OUT_W-1:0];
    err      = err_wide[OUT_W] ? (OUT_W'(0) - err_lo) : err_lo;
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_apx_d = s1_apx_q;
    if (load) begin
      s1_v_d   = 1'b1;
      s1_a_d   = src_a;
      s1_b_d   = src_b;
      s1_apx_d = bus.in_approx;
    end else if (s1_adv) begin
      s1_v_d   = 1'b0;
    end

    s2_v_d     = s2_v_q;
    s2_exact_d = s2_exact_q;
    s2_err_d   = s2_err_q;
    s2_viol_d  = s2_viol_q;
    if (s2_adv) begin
      s2_v_d     = s1_v_q;
      s2_exact_d = exact;
      s2_err_d   = err;
      s2_viol_d  = int'(err) > ET;
    end
  end

  always_comb begin
    max_err_d    = max_err_q;
    viol_cnt_d   = viol_cnt_q;
    sample_cnt_d = sample_cnt_q;
    if (clr) begin
      max_err_d    = '0;
      viol_cnt_d   = '0;
      sample_cnt_d = '0;
    end else if (retire) begin
      if (sample_cnt_q != CNT_MAX) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (s2_viol_q && (viol_cnt_q != CNT_MAX)) viol_cnt_d = viol_cnt_q + CNT_W'(1);
      if (s2_err_q > max_err_q) max_err_d = s2_err_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (load) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_MAX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_v_q && !s2_v_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      s1_v_q       <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_apx_q     <= '0;
      s2_v_q       <= 1'b0;
      s2_exact_q   <= '0;
      s2_err_q     <= '0;
      s2_viol_q    <= 1'b0;
      max_err_q    <= '0;
      viol_cnt_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      s1_v_q       <= s1_v_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_apx_q     <= s1_apx_d;
      s2_v_q       <= s2_v_d;
      s2_exact_q   <= s2_exact_d;
      s2_err_q     <= s2_err_d;
      s2_viol_q    <= s2_viol_d;
      max_err_q    <= max_err_d;
      viol_cnt_q   <= viol_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // in_ready is held low during reset so every output reads zero while rst is high.
  assign bus.in_ready  = (MODE == 0) && !rst && s1_free;
  assign bus.sweep_a   = (MODE == 1) ? idx_q[IW-1:W] : '0;
  assign bus.sweep_b   = (MODE == 1) ? idx_q[W-1:0]  : '0;
  assign bus.out_valid = s2_v_q;
  assign bus.out_exact = s2_exact_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_viol  = s2_viol_q;
  assign max_err       = max_err_q;
  assign viol_cnt      = viol_cnt_q;
  assign sample_cnt    = sample_cnt_q;
  assign sweep_busy    = (state_q == SWEEP) || (state_q == DRAIN);
  assign sweep_done    = (state_q == DONE);
endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// tb/tb_abs_diff_err_monitor.sv - directed self-checking bench for abs_diff_err_monitor
// Three instances: stream mode, sweep mode, and stream mode with 4-bit counters.
module tb_abs_diff_err_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clear0 = 1'b0, clear1 = 1'b0, clear4 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  abs_diff_err_monitor_if #(.W(4), .OUT_W(5)) if0 ();
  abs_diff_err_monitor_if #(.W(4), .OUT_W(5)) if1 ();
  abs_diff_err_monitor_if #(.W(4), .OUT_W(5)) if4 ();

  logic [4:0]  max_err0, max_err1, max_err4;
  logic [15:0] viol_cnt0, sample_cnt0, viol_cnt1, sample_cnt1;
  logic [3:0]  viol_cnt4, sample_cnt4;
  logic        busy0, done0, busy1, done1, busy4, done4;

  abs_diff_err_monitor #(.W(4), .OUT_W(5), .ET(6), .CNT_W(16), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .start(start), .clear(clear0), .bus(if0.slave),
    .max_err(max_err0), .viol_cnt(viol_cnt0), .sample_cnt(sample_cnt0),
    .sweep_busy(busy0), .sweep_done(done0));

  abs_diff_err_monitor #(.W(4), .OUT_W(5), .ET(6), .CNT_W(16), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .start(start), .clear(clear1), .bus(if1.slave),
    .max_err(max_err1), .viol_cnt(viol_cnt1), .sample_cnt(sample_cnt1),
    .sweep_busy(busy1), .sweep_done(done1));

  abs_diff_err_monitor #(.W(4), .OUT_W(5), .ET(6), .CNT_W(4), .MODE(0)) u_c4 (
    .clk(clk), .rst(rst), .start(start), .clear(clear4), .bus(if4.slave),
    .max_err(max_err4), .viol_cnt(viol_cnt4), .sample_cnt(sample_cnt4),
    .sweep_busy(busy4), .sweep_done(done4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_exact [3] = '{3, 5, 11};
  int exp_err   [3] = '{0, 4, 9};
  int exp_viol  [3] = '{0, 0, 1};
  logic [3:0] b3_a [3] = '{4'd5, 4'd2, 4'd12};
  logic [3:0] b3_b [3] = '{4'd2, 4'd7, 4'd1};
  logic [4:0] b3_x [3] = '{5'd3, 5'd1, 5'd2};

  initial begin
    int acc, got, cyc;
    {if0.in_valid, if0.in_a, if0.in_b, if0.in_approx, if0.out_ready} = '0;
    {if1.in_valid, if1.in_a, if1.in_b, if1.in_approx} = '0;
    if1.out_ready = 1'b1;
    {if4.in_valid, if4.in_a, if4.in_b, if4.in_approx, if4.out_ready} = '0;

    repeat (3) step();
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_in_ready", if0.in_ready, 0);
    check("rst_sample_cnt", sample_cnt0, 0);

    // Test 1: a=9 b=3 approx=6
    rst = 1'b0;
    if0.out_ready = 1'b1;
    if0.in_valid = 1'b1; if0.in_a = 4'd9; if0.in_b = 4'd3; if0.in_approx = 5'd6;
    step();
    if0.in_valid = 1'b0;
    step();
    check("t1_out_valid", if0.out_valid, 1);
    check("t1_exact", if0.out_exact, 6);
    check("t1_err", if0.out_err, 0);
    check("t1_viol", if0.out_viol, 0);
    step();
    check("t1_sample_cnt", sample_cnt0, 1);
    check("t1_drained", if0.out_valid, 0);
    check("m0_sweep_idle", {busy0, done0, if0.sweep_a, if0.sweep_b}, 0);

    // Test 2: a=0 b=15 approx=4
    if0.in_valid = 1'b1; if0.in_a = 4'd0; if0.in_b = 4'd15; if0.in_approx = 5'd4;
    step();
    if0.in_valid = 1'b0;
    step();
    check("t2_exact", if0.out_exact, 15);
    check("t2_err", if0.out_err, 11);
    check("t2_viol", if0.out_viol, 1);
    step();
    check("t2_viol_cnt", viol_cnt0, 1);
    check("t2_max_err", max_err0, 11);
    check("t2_sample_cnt", sample_cnt0, 2);

    // Test 3: three beats, downstream stalled for the first 5 cycles
    acc = 0; got = 0;
    for (cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if0.out_ready = (cyc >= 5);
      if0.in_valid  = (acc < 3);
      if (acc < 3) begin
        if0.in_a = b3_a[acc]; if0.in_b = b3_b[acc]; if0.in_approx = b3_x[acc];
      end
      @(negedge clk);
      if (cyc == 2) check("t3_stall_in_ready", if0.in_ready, 0);
      if (if0.out_valid && if0.out_ready) begin
        check("t3_exact", if0.out_exact, exp_exact[got]);
        check("t3_err", if0.out_err, exp_err[got]);
        check("t3_viol", if0.out_viol, exp_viol[got]);
        got++;
      end
      if (if0.in_valid && if0.in_ready) acc++;
      step();
    end
    if0.in_valid = 1'b0;
    check("t3_delivered", got, 3);
    check("t3_sample_cnt", sample_cnt0, 5);
    check("t3_viol_cnt", viol_cnt0, 2);
    check("t3_max_err", max_err0, 11);

    // Test 6: saturating 4-bit counters, then clear racing a retire
    acc = 0; got = 0;
    if4.out_ready = 1'b1; if4.in_a = 4'd0; if4.in_b = 4'd15; if4.in_approx = 5'd0;
    for (cyc = 0; cyc < 60 && got < 20; cyc++) begin
      if4.in_valid = (acc < 20);
      @(negedge clk);
      if (if4.in_valid && if4.in_ready) acc++;
      if (if4.out_valid && if4.out_ready) got++;
      step();
    end
    if4.in_valid = 1'b0;
    check("t6_delivered", got, 20);
    check("t6_viol_sat", viol_cnt4, 15);
    check("t6_sample_sat", sample_cnt4, 15);
    check("t6_max_err", max_err4, 15);

    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1; if4.in_a = 4'd3; if4.in_b = 4'd1; if4.in_approx = 5'd2;
    step();
    if4.in_valid = 1'b0;
    step();
    check("t6_held", if4.out_valid, 1);
    clear4 = 1'b1; if4.out_ready = 1'b1;
    @(negedge clk);
    check("t6_clr_deliver_valid", if4.out_valid, 1);
    check("t6_clr_deliver_exact", if4.out_exact, 2);
    step();
    clear4 = 1'b0;
    check("t6_clr_sample", sample_cnt4, 0);
    check("t6_clr_viol", viol_cnt4, 0);
    check("t6_clr_max", max_err4, 0);
    check("t6_retired", if4.out_valid, 0);

    // Test 4: exhaustive sweep with approx tied to 0
    check("m1_in_ready", if1.in_ready, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_busy", busy1, 1);
    for (cyc = 0; cyc < 1000 && !done1; cyc++) step();
    check("t4_done", done1, 1);
    check("t4_sample_cnt", sample_cnt1, 256);
    check("t4_max_err", max_err1, 15);
    check("t4_viol_cnt", viol_cnt1, 90);
    check("t4_busy_after", busy1, 0);

    // Test 5: restart from DONE, reset mid-sweep, then a clean full sweep
    start = 1'b1;
    step();
    start = 1'b0;
    for (cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if ({if1.sweep_a, if1.sweep_b} == 8'd100) break;
    end
    check("t5_reached_idx", {if1.sweep_a, if1.sweep_b}, 100);
    check("t5_restart_cleared", sample_cnt1 < 16'd100, 1);
    rst = 1'b1;
    step();
    check("t5_rst_outs", {if1.out_valid, if1.out_exact, if1.out_err, if1.out_viol}, 0);
    check("t5_rst_stats", {max_err1, viol_cnt1, sample_cnt1}, 0);
    check("t5_rst_fsm", {busy1, done1, if1.sweep_a, if1.sweep_b}, 0);
    rst = 1'b0;
    step();
    check("t5_idle", {busy1, done1}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (cyc = 0; cyc < 1000 && !done1; cyc++) step();
    check("t5_done", done1, 1);
    check("t5_sample_cnt", sample_cnt1, 256);
    check("t5_viol_cnt", viol_cnt1, 90);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
